// File: rtl/dmem_responder.sv
// dmem_responder: load/store data-memory responder with configurable wait states.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_i             request valid, accepted only in IDLE
//   we_i              1 = store, 0 = load
//   addr_i            byte address
//   size_i            00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i        load extension: 1 zero-extend, 0 sign-extend
//   wdata_i           right-aligned store data
//   rdata_o           extended load data, zero for stores and faults
//   ready_o           one-cycle response strobe
//   err_o             fault flag, valid with ready_o
//   busy_o            request in flight
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        we_q, uns_q, ready_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
    logic [31:0] a, word, wd_rep, rdata_d;
    logic [1:0]  sz;
    logic        we, uns, fault_d;
    logic [AW-1:0] idx;
    logic [15:0] half;
    logic [7:0]  byt;
    logic [3:0]  be;
    // With zero wait states the response is formed straight from the live
    // request in IDLE; otherwise it comes from the latched copy.
    always_comb begin
        a       = state_q == IDLE ? addr_i : addr_q;
        sz      = state_q == IDLE ? size_i : size_q;
        we      = state_q == IDLE ? we_i : we_q;
        uns     = state_q == IDLE ? unsigned_i : uns_q;
        idx     = a[AW+1:2];
        word    = mem_q[idx];
        fault_d = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
                  || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
        byt     = word[{a[1:0], 3'b000} +: 8];
        half    = a[1] ? word[31:16] : word[15:0];
        rdata_d = (fault_d || we) ? 32'd0 :
                  sz == 2'b00 ? {{24{byt[7] & ~uns}}, byt} :
                  sz == 2'b01 ? {{16{half[15] & ~uns}}, half} : word;
        be      = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                  size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_rep  = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                  size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (req_i) begin
                    we_q    <= we_i;
                    addr_q  <= addr_i;
                    size_q  <= size_i;
                    uns_q   <= unsigned_i;
                    wdata_q <= wdata_i;
                    cnt_q   <= 3'(LATENCY);
                    if (LATENCY == 0) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= fault_d;
                        rdata_q <= rdata_d;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= fault_d;
                        rdata_q <= rdata_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                end
            endcase
        end
    end
    // Store commits on the edge that ends RESP; a reset in RESP cancels it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && we_q && !err_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[idx][8*i +: 8] <= wd_rep[8*i +: 8];
    end
    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder at latency 2 and 0.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b1, req = 1'b0, sel = 1'b0, we = 1'b0, uns = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  size = 2'b10;
    logic        req2, req0;
    logic [31:0] rd2, rd0;
    logic        rdy2, rdy0, err2, err0, busy2, busy0;
    assign req2 = req & ~sel;
    assign req0 = req & sel;
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_i(req2), .we_i(we), .addr_i(addr), .size_i(size),
        .unsigned_i(uns), .wdata_i(wdata), .rdata_o(rd2), .ready_o(rdy2), .err_o(err2), .busy_o(busy2));
    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we), .addr_i(addr), .size_i(size),
        .unsigned_i(uns), .wdata_i(wdata), .rdata_o(rd0), .ready_o(rdy0), .err_o(err0), .busy_o(busy0));
    int checks = 0, failures = 0;
    typedef struct {
        string       name;
        logic        s, w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] wd, exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];
    function automatic vec_t mk(input string n, input logic s, input logic w, input logic [31:0] a,
                                input logic [1:0] sz, input logic u, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.s = s; v.w = w; v.a = a; v.sz = sz; v.u = u; v.wd = wd; v.exp_rd = er; v.exp_err = ee;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic access(input logic s, input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        sel = s; req = 1'b1; we = w; addr = a; size = sz; uns = u; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = -1; rd = '0; er = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (s ? rdy0 : rdy2) begin
                lat = i; rd = s ? rd0 : rd2; er = s ? err0 : err2;
                break;
            end
        end
    endtask
    task automatic load_chk(input string n, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic er; int lat;
        access(1'b0, 1'b0, a, 2'b10, 1'b0, 32'd0, rd, er, lat);
        chk({n, " rdata"}, rd, exp);
        chk({n, " err"}, 32'(er), 32'd0);
        chk({n, " lat"}, 32'(lat), 32'd3);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [31:0] rd; logic er; int lat; logic seen;
        vecs.push_back(mk("st_w",       0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk("ld_w",       0, 0, 32'h10, 2'd2, 0, 32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk("st_b",       0, 1, 32'h12, 2'd0, 0, 32'hFFFFFF5A, 32'h0,        0));
        vecs.push_back(mk("ld_w_lane",  0, 0, 32'h10, 2'd2, 0, 32'h0,        32'hDE5ABEEF, 0));
        vecs.push_back(mk("ld_b_s",     0, 0, 32'h12, 2'd0, 0, 32'h0,        32'h0000005A, 0));
        vecs.push_back(mk("ld_h_s",     0, 0, 32'h12, 2'd1, 0, 32'h0,        32'hFFFFDE5A, 0));
        vecs.push_back(mk("ld_h_u",     0, 0, 32'h12, 2'd1, 1, 32'h0,        32'h0000DE5A, 0));
        vecs.push_back(mk("ld_b3_s",    0, 0, 32'h13, 2'd0, 0, 32'h0,        32'hFFFFFFDE, 0));
        vecs.push_back(mk("ld_b0_u",    0, 0, 32'h10, 2'd0, 1, 32'h0,        32'h000000EF, 0));
        vecs.push_back(mk("ld_h0_s",    0, 0, 32'h10, 2'd1, 0, 32'h0,        32'hFFFFBEEF, 0));
        vecs.push_back(mk("st_h",       0, 1, 32'h14, 2'd1, 0, 32'h1234ABCD, 32'h0,        0));
        vecs.push_back(mk("st_b3",      0, 1, 32'h17, 2'd0, 0, 32'h00000080, 32'h0,        0));
        vecs.push_back(mk("ld_w5",      0, 0, 32'h14, 2'd2, 0, 32'h0,        32'h8000ABCD, 0));
        vecs.push_back(mk("ld_b7_s",    0, 0, 32'h17, 2'd0, 0, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk("ld_b7_u",    0, 0, 32'h17, 2'd0, 1, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk("st_h2",      0, 1, 32'h16, 2'd1, 0, 32'h0000C3D2, 32'h0,        0));
        vecs.push_back(mk("ld_h2_u",    0, 0, 32'h16, 2'd1, 1, 32'h0,        32'h0000C3D2, 0));
        vecs.push_back(mk("ld_w5b",     0, 0, 32'h14, 2'd2, 0, 32'h0,        32'hC3D2ABCD, 0));
        vecs.push_back(mk("f_ld_w_mis", 0, 0, 32'h11, 2'd2, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("f_ld_w_mis2",0, 0, 32'h12, 2'd2, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("f_ld_h_mis", 0, 0, 32'h11, 2'd1, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("f_st_h_mis", 0, 1, 32'h13, 2'd1, 0, 32'h0000FFFF, 32'h0,        1));
        vecs.push_back(mk("f_st_sz3",   0, 1, 32'h10, 2'd3, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("f_ld_sz3",   0, 0, 32'h10, 2'd3, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("f_ld_oor",   0, 0, 32'h1000, 2'd2, 0, 32'h0,      32'h0,        1));
        vecs.push_back(mk("f_st_oor",   0, 1, 32'h1000, 2'd2, 0, 32'h11111111, 32'h0,      1));
        vecs.push_back(mk("f_ld_hi",    0, 0, 32'h80000010, 2'd2, 0, 32'h0,  32'h0,        1));
        vecs.push_back(mk("ld_after_f", 0, 0, 32'h10, 2'd2, 0, 32'h0,        32'hDE5ABEEF, 0));
        vecs.push_back(mk("ld_w0",      0, 0, 32'h0,  2'd2, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk("ld_last",    0, 0, 32'hFFC, 2'd2, 0, 32'h0,       32'h0,        0));
        vecs.push_back(mk("z_f_st_oor", 1, 1, 32'h40, 2'd2, 0, 32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk("z_ld_last",  1, 0, 32'h3C, 2'd2, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk("z_st_b",     1, 1, 32'h3F, 2'd0, 0, 32'h000000A5, 32'h0,        0));
        vecs.push_back(mk("z_ld_w",     1, 0, 32'h3C, 2'd2, 0, 32'h0,        32'hA5000000, 0));
        vecs.push_back(mk("z_ld_b_s",   1, 0, 32'h3F, 2'd0, 0, 32'h0,        32'hFFFFFFA5, 0));
        vecs.push_back(mk("z_f_ld_oor", 1, 0, 32'h40, 2'd2, 0, 32'h0,        32'h0,        1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(rdy2), 32'd0);
        chk("reset err", 32'(err2), 32'd0);
        chk("reset rdata", rd2, 32'd0);
        chk("reset busy", 32'(busy2), 32'd0);
        chk("reset busy0", 32'(busy0), 32'd0);
        rst = 1'b0;
        foreach (vecs[k]) begin
            access(vecs[k].s, vecs[k].w, vecs[k].a, vecs[k].sz, vecs[k].u, vecs[k].wd, rd, er, lat);
            chk({vecs[k].name, " rdata"}, rd, vecs[k].exp_rd);
            chk({vecs[k].name, " err"}, 32'(er), 32'(vecs[k].exp_err));
            chk({vecs[k].name, " lat"}, 32'(lat), vecs[k].s ? 32'd1 : 32'd3);
        end
        // Reset during WAIT: no response and no commit.
        @(negedge clk);
        sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'b10; wdata = 32'h12345678;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("wait busy", 32'(busy2), 32'd1);
        chk("wait ready", 32'(rdy2), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait busy", 32'(busy2), 32'd0);
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= rdy2; end
        chk("rst_wait no ready", 32'(seen), 32'd0);
        load_chk("rst_wait ld", 32'h20, 32'h0);
        // Reset during RESP: the store must not commit.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'b10; wdata = 32'h12345678;
        @(posedge clk);
        #1 req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (rdy2) begin seen = 1'b1; rst = 1'b1; end
        end
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp saw ready", 32'(seen), 32'd1);
        load_chk("rst_resp ld", 32'h20, 32'h0);
        // Inputs wiggled during WAIT must not affect the access.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h24; size = 2'b10; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = rdy2;
            addr = 32'h28 + 32'(4 * i);
            wdata = $urandom;
        end
        chk("iso ready", 32'(seen), 32'd1);
        load_chk("iso ld24", 32'h24, 32'hCAFEF00D);
        load_chk("iso ld28", 32'h28, 32'h0);
        load_chk("iso ld2c", 32'h2C, 32'h0);
        // Zero latency, req held six cycles: store then loads back-to-back.
        @(negedge clk);
        sel = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h8; size = 2'b10; uns = 1'b0; wdata = 32'h55AA1234;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("b2b ready c%0d", c), 32'(rdy0), 32'(c % 2));
            chk($sformatf("b2b busy c%0d", c), 32'(busy0), 32'(c % 2));
            if (c == 1) chk("b2b store rdata", rd0, 32'h0);
            if (c == 3 || c == 5) chk($sformatf("b2b load rdata c%0d", c), rd0, 32'h55AA1234);
            if (c == 1) we = 1'b0;
            if (c == 6) req = 1'b0;
        end
        @(negedge clk);
        chk("b2b idle ready", 32'(rdy0), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
